// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out frame controller: start, WIDTH qualified bits, valid/ready hand-off.
// Optional even-parity bit after the data bits when SIPO_PARITY_EN is defined.
module sipo_frame_ctrl #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             bit_valid,
   input  logic             data_in,
   input  logic             out_ready,
   output logic             busy,
   output logic             out_valid,
   output logic [WIDTH-1:0] data_out,
   output logic             overrun,
   output logic             parity_err,
   output logic [7:0]       frame_cnt
);
   // state  | meaning
   // IDLE   | waiting for start; bit_valid ignored
   // SHIFT  | collecting WIDTH data bits
   // PARITY | waiting for the even-parity bit (SIPO_PARITY_EN only)
   // HOLD   | word presented on out_valid/data_out until out_ready
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY, HOLD} state_t;

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sreg_q, sreg_d, sreg_shift;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   data_out_q, data_out_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;
   logic               overrun_q, overrun_d;
   logic [7:0]         frame_cnt_q, frame_cnt_d;
`ifdef SIPO_PARITY_EN
   logic               parity_err_q, parity_err_d;
`endif

   always_comb begin
      state_d     = state_q;
      sreg_d      = sreg_q;
      cnt_d       = cnt_q;
      data_out_d  = data_out_q;
      out_valid_d = out_valid_q;
      overrun_d   = overrun_q;
      frame_cnt_d = frame_cnt_q;
`ifdef SIPO_PARITY_EN
      parity_err_d = parity_err_q;
`endif
      sreg_shift = MSB_FIRST ? {sreg_q[WIDTH-2:0], data_in} : {data_in, sreg_q[WIDTH-1:1]};

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = SHIFT;
               cnt_d     = '0;
               sreg_d    = '0;
               overrun_d = 1'b0;
`ifdef SIPO_PARITY_EN
               parity_err_d = 1'b0;
`endif
            end
         end
         SHIFT: begin
            if (bit_valid) begin
               sreg_d = sreg_shift;
               cnt_d  = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  data_out_d = sreg_shift;
`ifdef SIPO_PARITY_EN
                  state_d = PARITY;
`else
                  state_d     = HOLD;
                  out_valid_d = 1'b1;
`endif
               end
            end
         end
`ifdef SIPO_PARITY_EN
         PARITY: begin
            // data_out already holds the data bits, so parity is checked against it
            if (bit_valid) begin
               parity_err_d = (^data_out_q) ^ data_in;
               state_d      = HOLD;
               out_valid_d  = 1'b1;
            end
         end
`endif
         HOLD: begin
            if (bit_valid) overrun_d = 1'b1;
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               frame_cnt_d = frame_cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         sreg_q      <= '0;
         cnt_q       <= '0;
         data_out_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         frame_cnt_q <= '0;
`ifdef SIPO_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sreg_q      <= sreg_d;
         cnt_q       <= cnt_d;
         data_out_q  <= data_out_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
         frame_cnt_q <= frame_cnt_d;
`ifdef SIPO_PARITY_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign data_out  = data_out_q;
   assign overrun   = overrun_q;
   assign frame_cnt = frame_cnt_q;
`ifdef SIPO_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl: MSB-first and LSB-first instances checked each cycle against a queue-based model.
module tb_sipo_frame_ctrl;
   localparam int W = 4;
`ifdef SIPO_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, start, bit_valid, data_in, out_ready;
   logic busy_m, ov_m, ovr_m, pe_m, busy_l, ov_l, ovr_l, pe_l;
   logic [W-1:0] do_m, do_l;
   logic [7:0] fc_m, fc_l;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .data_in(data_in),
      .out_ready(out_ready), .busy(busy_m), .out_valid(ov_m), .data_out(do_m),
      .overrun(ovr_m), .parity_err(pe_m), .frame_cnt(fc_m));

   sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .data_in(data_in),
      .out_ready(out_ready), .busy(busy_l), .out_valid(ov_l), .data_out(do_l),
      .overrun(ovr_l), .parity_err(pe_l), .frame_cnt(fc_l));

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame progress expressed as the list of received bits
   bit           m_busy, m_valid, m_ovr, m_perr;
   bit           m_bits[$];
   logic [W-1:0] m_word_m, m_word_l;
   logic [7:0]   m_cnt;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 0; m_valid = 0; m_ovr = 0; m_perr = 0;
         m_bits.delete();
         m_word_m = '0; m_word_l = '0; m_cnt = '0;
      end else if (!m_busy) begin
         if (start) begin
            m_busy = 1; m_ovr = 0; m_perr = 0;
            m_bits.delete();
         end
      end else if (m_valid) begin
         if (bit_valid) m_ovr = 1;
         if (out_ready) begin
            m_valid = 0; m_busy = 0; m_cnt = m_cnt + 8'd1;
         end
      end else if (m_bits.size() < W) begin
         if (bit_valid) begin
            m_bits.push_back(data_in);
            if (m_bits.size() == W) begin
               for (int i = 0; i < W; i++) begin
                  m_word_m[W-1-i] = m_bits[i];
                  m_word_l[i]     = m_bits[i];
               end
               if (!PAR) m_valid = 1;
            end
         end
      end else if (bit_valid) begin
         m_perr  = (^m_word_m) ^ data_in;
         m_valid = 1;
      end
   end

   always @(negedge clk) begin
      chk("busy_msb", busy_m, m_busy);
      chk("busy_lsb", busy_l, m_busy);
      chk("out_valid_msb", ov_m, m_valid);
      chk("out_valid_lsb", ov_l, m_valid);
      chk("data_out_msb", do_m, m_word_m);
      chk("data_out_lsb", do_l, m_word_l);
      chk("overrun_msb", ovr_m, m_ovr);
      chk("overrun_lsb", ovr_l, m_ovr);
      chk("parity_err_msb", pe_m, m_perr);
      chk("parity_err_lsb", pe_l, m_perr);
      chk("frame_cnt_msb", fc_m, m_cnt);
      chk("frame_cnt_lsb", fc_l, m_cnt);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send_bit(bit b, int gap);
      repeat (gap) tick();
      bit_valid = 1'b1; data_in = b;
      tick();
      bit_valid = 1'b0; data_in = 1'b0;
   endtask

   // first transmitted bit is w[3]
   task automatic frame(logic [3:0] w, int gap, bit p);
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 3; i >= 0; i--) send_bit(w[i], gap);
      if (PAR) send_bit(p, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; start = 1'b0; bit_valid = 1'b0; data_in = 1'b0; out_ready = 1'b1;
      #1 rst = 1'b1;
      #13 rst = 1'b0;
      tick();
      chk("reset_busy", busy_m, 1'b0);
      chk("reset_data", do_m, 4'b0000);

      // 1: back-to-back bits 1,0,1,1 with out_ready high
      bit_valid = 1'b1; tick(); bit_valid = 1'b0;   // ignored in IDLE
      frame(4'b1011, 0, 1'b1);
      chk("t1_valid", ov_m, 1'b1);
      chk("t1_word_msb", do_m, 4'b1011);
      chk("t1_word_lsb", do_l, 4'b1101);
      tick();
      chk("t1_valid_drop", ov_m, 1'b0);
      chk("t1_cnt", fc_m, 8'd1);
      chk("t1_busy", busy_m, 1'b0);

      // 2: gaps of 0..3 cycles between bits
      start = 1'b1; tick(); start = 1'b0;
      send_bit(1'b1, 0); send_bit(1'b0, 1); send_bit(1'b1, 2); send_bit(1'b1, 3);
      if (PAR) send_bit(1'b1, 2);
      chk("t2_word_msb", do_m, 4'b1011);
      chk("t2_word_lsb", do_l, 4'b1101);
      tick();

      // 3: backpressure with overrun
      out_ready = 1'b0;
      frame(4'b1011, 0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         bit_valid = (i == 1 || i == 3); data_in = 1'b0;
         tick();
      end
      bit_valid = 1'b0;
      chk("t3_hold_word", do_m, 4'b1011);
      chk("t3_overrun", ovr_m, 1'b1);
      out_ready = 1'b1; tick();
      chk("t3_handshake", ov_m, 1'b0);
      tick();
      chk("t3_overrun_sticky", ovr_m, 1'b1);
      start = 1'b1; tick(); start = 1'b0;
      chk("t3_overrun_clear", ovr_m, 1'b0);
      for (int i = 3; i >= 0; i--) send_bit(i[0], 0);
      if (PAR) send_bit(1'b0, 0);
      tick();

      // 4: asynchronous reset mid-frame
      start = 1'b1; tick(); start = 1'b0;
      send_bit(1'b1, 0); send_bit(1'b1, 0);
      #4 rst = 1'b1;
      #1 chk("t4_rst_busy", busy_m, 1'b0);
      chk("t4_rst_cnt", fc_m, 8'd0);
      chk("t4_rst_data", do_m, 4'b0000);
      #2 rst = 1'b0;
      tick();
      frame(4'b0110, 0, 1'b0);
      chk("t4_word_msb", do_m, 4'b0110);
      chk("t4_word_lsb", do_l, 4'b0110);
      tick();

      // 5: start held during SHIFT and the HOLD handshake
      start = 1'b1; tick();
      for (int i = 3; i >= 0; i--) send_bit(i != 2, 0);
      if (PAR) send_bit(1'b1, 0);
      tick();
      start = 1'b0;
      chk("t5_idle", busy_m, 1'b0);
      tick();
      chk("t5_still_idle", busy_m, 1'b0);

      // 256 frames from reset wrap the counter
      rst = 1'b1; tick(); rst = 1'b0; tick();
      for (int i = 0; i < 256; i++) begin
         logic [3:0] w;
         w = 4'(i);
         frame(w, 0, ^w);
         tick();
         if (i == 254) chk("t5_cnt_255", fc_m, 8'd255);
      end
      chk("t5_cnt_wrap", fc_m, 8'd0);

`ifdef SIPO_PARITY_EN
      // 6: parity good, then bad
      frame(4'b1011, 0, 1'b1);
      chk("t6_perr_ok", pe_m, 1'b0);
      tick();
      frame(4'b1011, 0, 1'b0);
      chk("t6_perr_bad", pe_m, 1'b1);
      chk("t6_valid", ov_m, 1'b1);
      tick();
`endif

      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
Controller that sequences serial-in/parallel-out capture of framed words.
- Starts a frame on command, counts WIDTH qualified serial bits into an internal shift register, then presents the assembled word on a valid/ready output handshake.
- Sits between a serial bit source (line receiver, test stimulus) and a parallel consumer.
- Tracks delivered-frame count and overrun.

Parameters:
WIDTH, 4, number of data bits per frame (>= 2)
MSB_FIRST, 1, 1: first received bit lands in data_out[WIDTH-1]; 0: first bit lands in data_out[0]

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin a frame; honoured only in IDLE
bit_valid  input  1  data_in is a valid serial bit this cycle
data_in  input  1  serial data bit
out_ready  input  1  consumer accepts data_out this cycle
busy  output  1  high in any state other than IDLE
out_valid  output  1  data_out holds a complete frame
data_out  output  WIDTH  assembled parallel word, registered
overrun  output  1  sticky: bit_valid seen while word waiting in HOLD
parity_err  output  1  parity result of last frame (see Optional Feature)
frame_cnt  output  8  count of frames handed off, wraps 255->0

Behaviour:
- Reset (async, rst=1): state=IDLE, shift register=0, bit counter=0, busy=0, out_valid=0, data_out=0, overrun=0, parity_err=0, frame_cnt=0. Reset mid-frame aborts the frame; no partial word is ever output.
- States: IDLE, SHIFT, [PARITY when enabled], HOLD.
- IDLE:
  - start=1 -> SHIFT next cycle; clears bit counter, shift register and overrun.
  - bit_valid is ignored.
- SHIFT:
  - Each cycle with bit_valid=1 shifts data_in and increments the counter.
  - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], data_in}. MSB_FIRST=0: sreg <= {data_in, sreg[WIDTH-1:1]}.
  - bit_valid=0 cycles hold state; gaps are unlimited.
  - On the bit that makes the count WIDTH: data_out loads the final word (including that bit) and the FSM enters HOLD (or PARITY). out_valid rises the cycle after the last bit is sampled (latency 1).
- HOLD:
  - out_valid=1; data_out is stable.
  - out_valid && out_ready -> IDLE next cycle, out_valid=0, frame_cnt+1 (modulo 256).
  - bit_valid=1 in HOLD sets overrun; the bit is dropped and data_out is unchanged.
  - out_ready with out_valid=0 has no effect.
- start is ignored when busy=1, including start coincident with the HOLD handshake. A new start is accepted only from IDLE, so the minimum gap between frames is one IDLE cycle.
- overrun clears only on rst or an accepted start.
- frame_cnt wraps 255->0 silently.

Optional Feature:
Macro SIPO_PARITY_EN.
- Defined: after WIDTH data bits the FSM enters PARITY and waits for one more bit_valid.
  - That bit is even parity over the data bits.
  - On the cycle it is sampled: parity_err <= (^data_out) ^ data_in, and the FSM moves to HOLD.
  - out_valid latency is measured from the parity bit.
  - parity_err holds until the next accepted start or rst.
- Undefined: no PARITY state; data bits go straight to HOLD; parity_err tied to 0.

Test Plan:
1. WIDTH=4, MSB_FIRST=1. start, then bits 1,0,1,1 on consecutive cycles with out_ready=1 -> out_valid for exactly one cycle, starting the cycle after the 4th bit; data_out=4'b1011; frame_cnt=1; busy returns to 0.
2. Same bits with bit_valid gaps of 0-3 idle cycles, plus MSB_FIRST=0 build -> MSB_FIRST=1 gives 4'b1011; MSB_FIRST=0 gives 4'b1101; no early out_valid.
3. Backpressure: out_ready=0 for 5 cycles in HOLD, with bit_valid=1, data_in=0 pulsed twice -> data_out stays 1011, overrun=1; out_ready=1 -> handshake completes; overrun stays 1 until the next start.
4. Reset mid-frame: after 2 of 4 bits, pulse rst asynchronously (not clock aligned) -> all outputs 0 immediately. A fresh start with 0,1,1,0 -> data_out=4'b0110.
5. start asserted during SHIFT and during the HOLD handshake -> ignored; frame completes normally. 256 back-to-back frames -> frame_cnt wraps to 0.
6. SIPO_PARITY_EN defined: bits 1,0,1,1 then parity 1 -> parity_err=0. Same data with parity 0 -> parity_err=1. out_valid follows the parity bit by one cycle.
